counter_host: RTL and testbench
===============================

# counter_host

Host-side driver for the team's loadable up-counter interface (set / enable / read strobes, 8-bit load bus, 8-bit read-back bus). The block accepts commands over a valid/ready port and converts them into correctly timed strobe sequences: load a value, step N times, or read back. It keeps a shadow copy of the expected count, samples the counter's read-back on READ, and reports the value plus a mismatch flag. It sits on the opposite side of the counter's IO pins and serves as both bring-up driver and self-checker.

## Interface
- `WIDTH`, 8: counter and data width.
- `READ_LAT`, 1: register stages between `cnt_rd` assertion and valid `cnt_q` at this block's input (0..3).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_op`  in  2  00 LOAD, 01 STEP, 10 READ, 11 NOP.
- `cmd_data`  in  WIDTH  load value (LOAD) or step count N (STEP).
- `cnt_set`  out  1  counter load strobe.
- `cnt_en`  out  1  counter increment enable.
- `cnt_rd`  out  1  counter read/output enable.
- `cnt_load`  out  WIDTH  counter load bus.
- `cnt_q`  in  WIDTH  counter read-back bus.
- `rsp_valid`  out  1  READ result available; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  WIDTH  sampled counter value.
- `rsp_mismatch`  out  1  `rsp_data` differs from the shadow value.
- `err_sticky`  out  1  set on any mismatch; cleared only by `rst`.

## Operation
- FSM states: IDLE, LOAD, STEP, RD_WAIT, RSP. `cmd_ready` = 1 only in IDLE.
- IDLE, accepting LOAD → LOAD. Assert `cnt_set` with `cnt_load = cmd_data` for exactly one cycle. Set shadow to `cmd_data`. Return to IDLE.
- IDLE, accepting STEP with N > 0 → STEP. Assert `cnt_en` for exactly N consecutive cycles, tracked by an internal down-counter. Shadow += N, mod 2^WIDTH. Return to IDLE.
- STEP with N = 0: accept, no strobes, stay in IDLE.
- IDLE, accepting READ → RD_WAIT. Hold `cnt_rd` high for READ_LAT+1 cycles. Capture `cnt_q` on the last edge of that window.
- RD_WAIT → RSP. Compare the capture against the shadow. Present `rsp_data` and `rsp_mismatch` with `rsp_valid` high. Set `err_sticky` if mismatched.
- RSP: `rsp_valid` and `rsp_data` stay stable until `rsp_ready`, then return to IDLE. No new command is accepted while in RSP.
- NOP (op 11): accepted, no strobes, no response.
- At most one of `cnt_set`, `cnt_en`, `cnt_rd` is high in any cycle.
- `cnt_load` is 0 whenever `cnt_set` is low.
- Reset values: FSM IDLE, shadow 0 (matches the counter's reset value), `cmd_ready` 1. `cnt_set`, `cnt_en`, `cnt_rd`, `cnt_load`, `rsp_valid`, `rsp_data`, `rsp_mismatch` and `err_sticky` are all 0.
- `rst` mid-operation: all state returns to reset values immediately. A partial STEP sequence or a pending response is discarded.

## Timing
- All strobe outputs are registered and start the cycle after command acceptance.
- LOAD occupancy: 1 cycle; `cmd_ready` is high again the following cycle.
- STEP occupancy: N cycles. Maximum N = 2^WIDTH−1, which wraps the shadow to shadow−1.
- READ latency: acceptance to `rsp_valid` = READ_LAT+2 cycles.
- Shadow arithmetic is modulo 2^WIDTH; carries are dropped.

## Structure
- Shared package `counter_host_pkg`: op encodings (`OP_LOAD`, `OP_STEP`, `OP_READ`, `OP_NOP`) and the FSM state enum.
- Single module; no sub-module. The FSM, step down-counter, read-window counter and shadow register are all inline.

## Test plan
- Reset, then READ with `cnt_q` = 0x00 → `rsp_data` 0x00, `rsp_mismatch` 0, `err_sticky` 0.
- LOAD 0x5A → `cnt_set` high for 1 cycle with `cnt_load` 0x5A. Then READ returning 0x5A → no mismatch.
- LOAD 0xFE, then STEP 3 → `cnt_en` high for exactly 3 cycles. READ returning 0x01 → no mismatch (wrap).
- STEP 0 → no `cnt_en` pulse and `cmd_ready` high the next cycle. NOP → no strobes and no response.
- READ with a stubbed `cnt_q` = 0x13 while the shadow is 0x12 → `rsp_mismatch` 1 and `err_sticky` stays 1 through later matching reads. Holding `rsp_ready` low for 5 cycles → `rsp_valid` and `rsp_data` remain stable.
- Assert `rst` in the middle of STEP 10 → `cnt_en` drops immediately and the shadow is 0. A following READ of 0x00 → no mismatch.

Source files
------------

// File: rtl/counter_host_pkg.sv
// Shared definitions for the counter host driver: command opcodes and FSM states.
package counter_host_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_STEP = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_STEP    = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_RSP     = 3'd4
   } state_e;

endpackage

// File: rtl/counter_host.sv
// Host-side driver for the loadable up-counter: turns LOAD/STEP/READ commands into
// strobe sequences and checks read-back against a shadow copy of the count.
module counter_host
   import counter_host_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned READ_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             cnt_set,
   output logic             cnt_en,
   output logic             cnt_rd,
   output logic [WIDTH-1:0] cnt_load,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_mismatch,
   output logic             err_sticky
);

   localparam int unsigned RD_CNT_W = 3;

   state_e               r_state;
   state_e               w_next;
   logic                 w_accept;
   logic [WIDTH-1:0]     r_step_cnt;
   logic [RD_CNT_W-1:0]  r_rd_cnt;
   logic [WIDTH-1:0]     r_shadow;
   logic                 r_cmd_ready;
   logic                 r_cnt_set;
   logic                 r_cnt_en;
   logic                 r_cnt_rd;
   logic [WIDTH-1:0]     r_cnt_load;
   logic                 r_rsp_valid;
   logic [WIDTH-1:0]     r_rsp_data;
   logic                 r_rsp_mismatch;
   logic                 r_err_sticky;

   // Next-state decode; outputs below are registered from the next state.
   always_comb begin
      w_next   = r_state;
      w_accept = r_cmd_ready & cmd_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_LOAD: w_next = ST_LOAD;
                  OP_STEP: w_next = (cmd_data != '0) ? ST_STEP : ST_IDLE;
                  OP_READ: w_next = ST_RD_WAIT;
                  default: w_next = ST_IDLE;
               endcase
            end
         end
         ST_LOAD:    w_next = ST_IDLE;
         ST_STEP:    if (r_step_cnt == '0) w_next = ST_IDLE;
         ST_RD_WAIT: if (r_rd_cnt == '0) w_next = ST_RSP;
         ST_RSP:     if (rsp_ready) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_cnt_set   <= 1'b0;
         r_cnt_en    <= 1'b0;
         r_cnt_rd    <= 1'b0;
         r_cnt_load  <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cmd_ready <= (w_next == ST_IDLE);
         r_cnt_set   <= (w_next == ST_LOAD);
         r_cnt_load  <= (w_next == ST_LOAD) ? cmd_data : '0;
         r_cnt_en    <= (w_next == ST_STEP);
         // Read window spans READ_LAT+1 cycles; the final RD_WAIT cycle is the compare slot.
         r_cnt_rd    <= (w_next == ST_RD_WAIT) &&
                        ((r_state == ST_IDLE) || (r_rd_cnt > RD_CNT_W'(1)));
         r_rsp_valid <= (w_next == ST_RSP);
      end
   end

   // Step and read-window down-counters, shadow register, capture and compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step_cnt     <= '0;
         r_rd_cnt       <= '0;
         r_shadow       <= '0;
         r_rsp_data     <= '0;
         r_rsp_mismatch <= 1'b0;
         r_err_sticky   <= 1'b0;
      end else begin
         if (w_accept && (cmd_op == OP_STEP)) begin
            r_step_cnt <= cmd_data - WIDTH'(1);
            r_shadow   <= r_shadow + cmd_data;
         end else if ((r_state == ST_STEP) && (r_step_cnt != '0)) begin
            r_step_cnt <= r_step_cnt - WIDTH'(1);
         end

         if (w_accept && (cmd_op == OP_LOAD)) begin
            r_shadow <= cmd_data;
         end

         if (w_accept && (cmd_op == OP_READ)) begin
            r_rd_cnt <= RD_CNT_W'(READ_LAT + 1);
         end else if ((r_state == ST_RD_WAIT) && (r_rd_cnt != '0)) begin
            r_rd_cnt <= r_rd_cnt - RD_CNT_W'(1);
         end

         if ((r_state == ST_RD_WAIT) && (r_rd_cnt == RD_CNT_W'(1))) begin
            r_rsp_data <= cnt_q;
         end

         if ((r_state == ST_RD_WAIT) && (r_rd_cnt == '0)) begin
            r_rsp_mismatch <= (r_rsp_data != r_shadow);
            if (r_rsp_data != r_shadow) begin
               r_err_sticky <= 1'b1;
            end
         end
      end
   end

   assign cmd_ready    = r_cmd_ready;
   assign cnt_set      = r_cnt_set;
   assign cnt_en       = r_cnt_en;
   assign cnt_rd       = r_cnt_rd;
   assign cnt_load     = r_cnt_load;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_mismatch = r_rsp_mismatch;
   assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_counter_host.sv
// Directed self-checking bench for counter_host; cnt_q is driven as a stub value.
module tb_counter_host;
   import counter_host_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cnt_set;
   logic       cnt_en;
   logic       cnt_rd;
   logic [7:0] cnt_load;
   logic [7:0] cnt_q;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_mismatch;
   logic       err_sticky;

   int checks = 0;
   int errors = 0;

   counter_host #(.WIDTH(8), .READ_LAT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .cnt_set      (cnt_set),
      .cnt_en       (cnt_en),
      .cnt_rd       (cnt_rd),
      .cnt_load     (cnt_load),
      .cnt_q        (cnt_q),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_mismatch (rsp_mismatch),
      .err_sticky   (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Offer one command at a negedge; returns at the negedge after acceptance.
   task automatic issue(input logic [1:0] op, input logic [7:0] d);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_op    = op;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_data  = 8'h00;
   endtask

   task automatic do_load(input logic [7:0] d);
      issue(OP_LOAD, d);
      chk("load_set", 32'(cnt_set), 32'd1);
      chk("load_bus", 32'(cnt_load), 32'(d));
      chk("load_busy", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("load_set_off", 32'({cnt_set, cnt_load}), 32'd0);
      chk("load_ready", 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_step(input string tag, input logic [7:0] n, input int exp_cycles);
      int cnt;
      int overlap;
      cnt = 0;
      overlap = 0;
      issue(OP_STEP, n);
      for (int i = 0; i < exp_cycles + 4; i++) begin
         if (cnt_en) cnt++;
         if (int'(cnt_set) + int'(cnt_en) + int'(cnt_rd) > 1) overlap++;
         @(negedge clk);
      end
      chk(tag, 32'(cnt), 32'(exp_cycles));
      chk({tag, "_excl"}, 32'(overlap), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [7:0] q, input logic exp_mm,
                          input logic exp_err, input int hold);
      cnt_q     = q;
      rsp_ready = (hold == 0);
      issue(OP_READ, 8'h00);
      chk({tag, "_rd0"}, 32'(cnt_rd), 32'd1);
      @(negedge clk);
      chk({tag, "_rd1"}, 32'(cnt_rd), 32'd1);
      @(negedge clk);
      chk({tag, "_rd_off"}, 32'({cnt_rd, rsp_valid}), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_data"}, 32'(rsp_data), 32'(q));
      chk({tag, "_mm"}, 32'(rsp_mismatch), 32'(exp_mm));
      chk({tag, "_err"}, 32'(err_sticky), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, 32'({cmd_ready, rsp_valid, rsp_data}), 32'({1'b0, 1'b1, q}));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_done"}, 32'({cmd_ready, rsp_valid}), 32'b10);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_data  = 8'h00;
      cnt_q     = 8'h00;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_strobes", 32'({cnt_set, cnt_en, cnt_rd, cnt_load}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_mismatch, err_sticky}), 32'd0);

      do_read("read_zero", 8'h00, 1'b0, 1'b0, 0);

      do_load(8'h5A);
      do_read("read_5a", 8'h5A, 1'b0, 1'b0, 0);

      do_load(8'hFE);
      do_step("step3", 8'd3, 3);
      do_read("read_wrap", 8'h01, 1'b0, 1'b0, 0);

      issue(OP_STEP, 8'd0);
      chk("step0_en", 32'(cnt_en), 32'd0);
      chk("step0_ready", 32'(cmd_ready), 32'd1);

      issue(OP_NOP, 8'hFF);
      chk("nop_strobes", 32'({cnt_set, cnt_en, cnt_rd}), 32'd0);
      chk("nop_ready", 32'(cmd_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("nop_no_rsp", 32'(rsp_valid), 32'd0);
      do_read("read_after_nop", 8'h01, 1'b0, 1'b0, 0);

      do_load(8'h10);
      do_step("step255", 8'd255, 255);
      do_read("read_max_step", 8'h0F, 1'b0, 1'b0, 0);

      do_load(8'h12);
      do_read("read_mm", 8'h13, 1'b1, 1'b1, 5);
      do_read("read_sticky", 8'h12, 1'b0, 1'b1, 0);

      issue(OP_STEP, 8'd10);
      repeat (3) @(negedge clk);
      chk("mid_step_en", 32'(cnt_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_en", 32'(cnt_en), 32'd0);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid_err", 32'({err_sticky, rsp_valid}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_read("read_after_rst", 8'h00, 1'b0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
